mc_ctrl_fsm: RTL and testbench

- Multi-cycle main control FSM for the MIPS core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath selects, including ext_op for the immediate extender (00 zero, 01 sign, 1x shamt from imm[10:6]).
- Waits on a memory ready handshake; decodes opcode/funct from the instruction register, which is stable after FETCH.

---
 rtl/mc_ctrl_fsm.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle main control FSM for the MIPS core.
//
// Steps each instruction through fetch, decode, execute, memory and
// writeback, and drives every datapath select from the current state plus
// the opcode/funct fields of the instruction register. Memory accesses wait
// on mem_ready with no timeout.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   op, funct          IR[31:26] and IR[5:0], stable after FETCH
//   zero               ALU zero flag, used by beq/bne
//   mem_ready          memory finishes the current read/write this cycle
//   pc_write .. ext_op datapath enables and selects
//   illegal            one-cycle pulse in DECODE on an unsupported op/funct
//   state              current state encoding, for debug
//   instr_cnt          retired-instruction counter (optional)
//
// Build option: define MC_CTRL_PERF_CNT_EN to add the instr_cnt output and
// its counter. Without it the port and logic are absent.

module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] ext_op,
  output logic       illegal,
  output logic [3:0] state
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_JUMP      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;

  state_e state_r;
  state_e next_state_s;

  // Shift functs take the shift amount from imm[10:6] via the extender.
  function automatic logic is_shift_funct(input logic [5:0] f);
    logic r;
    case (f)
      F_SLL, F_SRL, F_SRA: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_r_funct(input logic [5:0] f);
    logic r;
    case (f)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT,
      F_SLL, F_SRL, F_SRA: r = 1'b1;
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state_s = S_FETCH;
    pc_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    pc_src       = 2'b00;
    ext_op       = 2'b00;
    illegal      = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ext_op    = 2'b01;
        // IR load and PC+4 happen together on the completing cycle.
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU computes PC + (sext(imm) << 2) into ALUOut for branches.
        alu_src_b = 2'b11;
        ext_op    = 2'b01;
        case (op)
          OP_LW, OP_SW:   next_state_s = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
          OP_J:           next_state_s = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI:
                          next_state_s = S_I_EXEC;
          OP_RTYPE: begin
            if (is_r_funct(funct)) begin
              next_state_s = S_R_EXEC;
            end else begin
              illegal      = 1'b1;
              next_state_s = S_FETCH;
            end
          end
          default: begin
            illegal      = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
        if (op == OP_LW) begin
          next_state_s = S_MEM_READ;
        end else begin
          next_state_s = S_MEM_WRITE;
        end
      end
      S_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WRITE;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        if (is_shift_funct(funct)) begin
          alu_src_b = 2'b10;
          ext_op    = 2'b10;
        end else begin
          alu_src_b = 2'b00;
          ext_op    = 2'b01;
        end
        next_state_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero)) begin
          pc_write = 1'b1;
        end else begin
          pc_write = 1'b0;
        end
        next_state_s = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        if ((op == OP_ANDI) || (op == OP_ORI)) begin
          ext_op = 2'b00;
        end else begin
          ext_op = 2'b01;
        end
        next_state_s = S_I_WB;
      end
      S_I_WB: begin
        reg_write    = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        pc_src       = 2'b10;
        next_state_s = S_FETCH;
      end
      default: begin
        // Unused encodings look like FETCH (without loading IR) and recover.
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ext_op       = 2'b01;
        next_state_s = S_FETCH;
      end
    endcase
  end

  assign state = state_r;

`ifdef MC_CTRL_PERF_CNT_EN
  logic        retire_s;
  logic [31:0] instr_cnt_r;

  // An instruction retires when FETCH is entered from a terminal state;
  // illegal returns from DECODE and recoveries from unused states do not.
  always_comb begin
    retire_s = 1'b0;
    if (next_state_s == S_FETCH) begin
      case (state_r)
        S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_I_WB, S_JUMP:
                 retire_s = 1'b1;
        default: retire_s = 1'b0;
      endcase
    end else begin
      retire_s = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_cnt_r <= 32'd0;
    end else if (retire_s) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign instr_cnt = instr_cnt_r;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm. Each scenario queues per-cycle
// stimulus (expected state plus inputs); expected outputs are derived from
// a state-table model and pushed to a scoreboard as stimulus is driven,
// then popped and compared on the falling edge.

module tb_mc_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src, ext_op;
  logic [3:0] state;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] ext_op;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
  } step_t;

  step_t stim_q[$];
  exp_t  sb_q[$];

  mc_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .ext_op     (ext_op),
    .illegal    (illegal),
    .state      (state)
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    .instr_cnt  (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000)
      return f inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                       6'b100101, 6'b101010, 6'b000000, 6'b000010, 6'b000011};
    return o inside {6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
                     6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101};
  endfunction

  // Expected outputs straight from the state table.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic [5:0] o,
                                     input logic [5:0] f, input logic z, input logic r);
    outs_t v;
    v = '0;
    case (st)
      4'd0: begin
        v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ext_op = 2'b01;
        if (r) begin v.ir_write = 1'b1; v.pc_write = 1'b1; end
      end
      4'd1: begin v.alu_src_b = 2'b11; v.ext_op = 2'b01; v.illegal = !legal(o, f); end
      4'd2: begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.ext_op = 2'b01; end
      4'd3: begin v.iord = 1'b1; v.mem_read = 1'b1; end
      4'd4: begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; end
      4'd5: begin v.iord = 1'b1; v.mem_write = 1'b1; end
      4'd6: begin
        v.alu_src_a = 1'b1; v.alu_op = 2'b10;
        if (f inside {6'b000000, 6'b000010, 6'b000011}) begin
          v.alu_src_b = 2'b10; v.ext_op = 2'b10;
        end else begin
          v.alu_src_b = 2'b00; v.ext_op = 2'b01;
        end
      end
      4'd7: begin v.reg_write = 1'b1; v.reg_dst = 1'b1; end
      4'd8: begin
        v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01;
        v.pc_write = ((o == 6'b000100) && z) || ((o == 6'b000101) && !z);
      end
      4'd9: begin
        v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 2'b11;
        v.ext_op = ((o == 6'b001100) || (o == 6'b001101)) ? 2'b00 : 2'b01;
      end
      4'd10: v.reg_write = 1'b1;
      4'd11: begin v.pc_write = 1'b1; v.pc_src = 2'b10; end
      default: begin v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ext_op = 2'b01; end
    endcase
    return v;
  endfunction

  function automatic outs_t act_outs();
    return {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, alu_src_b, alu_op, pc_src, ext_op, illegal};
  endfunction

  function automatic void add_step(input logic [3:0] st, input logic [5:0] o,
                                   input logic [5:0] f, input logic z, input logic r);
    step_t s;
    s.st = st; s.op = o; s.funct = f; s.zero = z; s.rdy = r;
    stim_q.push_back(s);
  endfunction

  task automatic test_reset();
    outs_t a, e;
    rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    a = act_outs();
    e = exp_outs(4'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    n_checks++;
    if (state !== 4'd0 || a !== e) begin
      n_fail++;
      $display("FAIL reset: state=%0d outs=%h, expected state=0 outs=%h", state, a, e);
    end
`ifdef MC_CTRL_PERF_CNT_EN
    n_checks++;
    if (instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: instr_cnt=%0d, expected 0", instr_cnt);
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    add_step(4'd0, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd0, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd0, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd2, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd3, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd3, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd3, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd4, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd0, 6'b100011, 6'd0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL lw step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    add_step(4'd0, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd2, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd5, 6'b101011, 6'd0, 1'b0, 1'b0);
    add_step(4'd5, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b101011, 6'd0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL sw step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_r_type();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    // sll, then add, then sra
    add_step(4'd0, 6'd0, 6'b000000, 1'b0, 1'b1);
    add_step(4'd1, 6'd0, 6'b000000, 1'b0, 1'b1);
    add_step(4'd6, 6'd0, 6'b000000, 1'b0, 1'b1);
    add_step(4'd7, 6'd0, 6'b000000, 1'b0, 1'b1);
    add_step(4'd0, 6'd0, 6'b100000, 1'b0, 1'b1);
    add_step(4'd1, 6'd0, 6'b100000, 1'b0, 1'b1);
    add_step(4'd6, 6'd0, 6'b100000, 1'b0, 1'b1);
    add_step(4'd7, 6'd0, 6'b100000, 1'b0, 1'b1);
    add_step(4'd0, 6'd0, 6'b000011, 1'b0, 1'b1);
    add_step(4'd1, 6'd0, 6'b000011, 1'b0, 1'b1);
    add_step(4'd6, 6'd0, 6'b000011, 1'b0, 1'b1);
    add_step(4'd7, 6'd0, 6'b000011, 1'b0, 1'b1);
    add_step(4'd0, 6'd0, 6'b000011, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL r_type step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    // beq taken, bne with zero=1 (not taken), beq not taken, bne taken, j
    add_step(4'd0, 6'b000100, 6'd0, 1'b1, 1'b1);
    add_step(4'd1, 6'b000100, 6'd0, 1'b1, 1'b1);
    add_step(4'd8, 6'b000100, 6'd0, 1'b1, 1'b1);
    add_step(4'd0, 6'b000101, 6'd0, 1'b1, 1'b1);
    add_step(4'd1, 6'b000101, 6'd0, 1'b1, 1'b1);
    add_step(4'd8, 6'b000101, 6'd0, 1'b1, 1'b1);
    add_step(4'd0, 6'b000100, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b000100, 6'd0, 1'b0, 1'b1);
    add_step(4'd8, 6'b000100, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b000101, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b000101, 6'd0, 1'b0, 1'b1);
    add_step(4'd8, 6'b000101, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b000010, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b000010, 6'd0, 1'b0, 1'b1);
    add_step(4'd11, 6'b000010, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b000010, 6'd0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL branch_jump step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_i_type();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    // ori (zero-extend), then addi (sign-extend)
    add_step(4'd0, 6'b001101, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b001101, 6'd0, 1'b0, 1'b1);
    add_step(4'd9, 6'b001101, 6'd0, 1'b0, 1'b1);
    add_step(4'd10, 6'b001101, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b001000, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b001000, 6'd0, 1'b0, 1'b1);
    add_step(4'd9, 6'b001000, 6'd0, 1'b0, 1'b1);
    add_step(4'd10, 6'b001000, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b001000, 6'd0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL i_type step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    // Bad opcode, then an R-type with an unsupported funct
    add_step(4'd0, 6'b111111, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b111111, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b000000, 6'b000001, 1'b0, 1'b1);
    add_step(4'd1, 6'b000000, 6'b000001, 1'b0, 1'b1);
    add_step(4'd0, 6'b000000, 6'b000001, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL illegal step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    add_step(4'd0, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd2, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd3, 6'b100011, 6'd0, 1'b0, 1'b0);
    add_step(4'd3, 6'b100011, 6'd0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
    // Still in MEM_READ: reset for two cycles with mem_ready raised.
    rst_n = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_mid_hold cycle %0d: state=%0d, expected 0", c, state);
      end
    end
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    a = act_outs();
    ex.o = exp_outs(4'd0, 6'b100011, 6'd0, 1'b0, 1'b0);
    n_checks++;
    if (state !== 4'd0 || a !== ex.o) begin
      n_fail++;
      $display("FAIL reset_mid_outs: state=%0d outs=%h, expected state=0 outs=%h", state, a, ex.o);
    end
    @(posedge clk); #1;
  endtask

`ifdef MC_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt();
    step_t s; exp_t ex, e; outs_t a; int k = 0;
    rst_n = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // lw, sw, j, then an illegal opcode
    add_step(4'd0, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd2, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd3, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd4, 6'b100011, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd2, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd5, 6'b101011, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b000010, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b000010, 6'd0, 1'b0, 1'b1);
    add_step(4'd11, 6'b000010, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b111111, 6'd0, 1'b0, 1'b1);
    add_step(4'd1, 6'b111111, 6'd0, 1'b0, 1'b1);
    add_step(4'd0, 6'b111111, 6'd0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      op = s.op; funct = s.funct; zero = s.zero; mem_ready = s.rdy;
      ex.st = s.st; ex.o = exp_outs(s.st, s.op, s.funct, s.zero, s.rdy);
      sb_q.push_back(ex);
      @(negedge clk);
      e = sb_q.pop_front(); a = act_outs(); n_checks++;
      if (state !== e.st || a !== e.o) begin
        n_fail++;
        $display("FAIL perf_seq step %0d: state=%0d outs=%h, expected state=%0d outs=%h", k, state, a, e.st, e.o);
      end
      k++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (instr_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL perf_cnt: instr_cnt=%0d, expected 3", instr_cnt);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_cnt_reset: instr_cnt=%0d, expected 0", instr_cnt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_r_type();
    test_branch_jump();
    test_i_type();
    test_illegal();
    test_reset_mid();
`ifdef MC_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
